// File: rtl/regfile_alu_sequencer.sv
// Execution stage: reads two operands through one register-file read port,
// runs an 8-bit ALU op and writes the result back through one write port.
module regfile_alu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic [2:0]            CmdOp,
    input  logic [ADDR_WIDTH-1:0] CmdSrcA,
    input  logic [ADDR_WIDTH-1:0] CmdSrcB,
    input  logic [ADDR_WIDTH-1:0] CmdDst,
    output logic [ADDR_WIDTH-1:0] ReadReg,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic [ADDR_WIDTH-1:0] WriteReg,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  WriteEn,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic                  Done
);

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        READ_B,
        EXEC,
        WRITE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] src_b_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH:0]   alu_wide;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c;

    always_comb begin
        state_nxt = state;
        CmdReady  = 1'b0;
        WriteEn   = 1'b0;
        Done      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                CmdReady  = 1'b1;
                accept    = CmdValid;
                state_nxt = CmdValid ? READ_A : IDLE;
            end
            READ_A: state_nxt = READ_B;
            READ_B: state_nxt = EXEC;
            EXEC:   state_nxt = WRITE;
            WRITE: begin
                CmdReady  = 1'b1;
                WriteEn   = 1'b1;
                Done      = 1'b1;
                accept    = CmdValid;
                state_nxt = CmdValid ? READ_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_wide = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = alu_wide[DATA_WIDTH-1:0];
                alu_c    = alu_wide[DATA_WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (A < B).
                alu_wide = {1'b0, op_a} - {1'b0, op_b};
                alu_res  = alu_wide[DATA_WIDTH-1:0];
                alu_c    = alu_wide[DATA_WIDTH];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_MOV: alu_res = op_a;
            OP_SHL: begin
                alu_res = {op_a[DATA_WIDTH-2:0], 1'b0};
                alu_c   = op_a[DATA_WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, op_a[DATA_WIDTH-1:1]};
                alu_c   = op_a[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            ReadReg  <= '0;
            Result   <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b1;
        end else begin
            state <= state_nxt;
            // ReadReg is registered ahead so it is stable for the whole read cycle.
            if (accept) begin
                op_q    <= CmdOp;
                src_b_q <= CmdSrcB;
                dst_q   <= CmdDst;
                ReadReg <= CmdSrcA;
            end
            if (state == READ_A) begin
                op_a    <= ReadData;
                ReadReg <= src_b_q;
            end
            if (state == READ_B) begin
                op_b <= ReadData;
            end
            if (state == EXEC) begin
                Result   <= alu_res;
                CarryOut <= alu_c;
                Zero     <= (alu_res == '0);
            end
        end
    end

    assign WriteReg  = dst_q;
    assign WriteData = Result;

endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
Command-driven execution stage that sits directly upstream of the 16x8 register file and drives its single read port and single write port. It accepts one ALU command at a time over a valid/ready handshake and reads both source operands sequentially through the one read port. It computes the 8-bit result and writes it back to the destination register. It also exports the result and flags to the rest of the datapath.

Parameters:
DATA_WIDTH, 8, register/operand width in bits
ADDR_WIDTH, 4, register address width (16 registers)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
CmdValid  in  1  command present
CmdReady  out  1  sequencer can accept a command this cycle
CmdOp  in  3  operation code
CmdSrcA  in  ADDR_WIDTH  source register A
CmdSrcB  in  ADDR_WIDTH  source register B
CmdDst  in  ADDR_WIDTH  destination register
ReadReg  out  ADDR_WIDTH  register file read address
ReadData  in  DATA_WIDTH  register file read data (combinational read)
WriteReg  out  ADDR_WIDTH  register file write address
WriteData  out  DATA_WIDTH  register file write data
WriteEn  out  1  register file write enable
Result  out  DATA_WIDTH  last computed result, held until next EXEC
CarryOut  out  1  carry/borrow/shift-out of last op
Zero  out  1  Result == 0
Done  out  1  one-cycle pulse, coincident with WriteEn

Behaviour:
- Reset (rst=0, async): state IDLE; CmdReady=1; ReadReg, WriteReg, WriteData, Result = 0; WriteEn, Done, CarryOut = 0; Zero=1; latched command and operands cleared. A reset mid-command aborts it and suppresses its write.
- States: IDLE -> READ_A -> READ_B -> EXEC -> WRITE -> (IDLE or READ_A).
- CmdReady=1 only in IDLE and WRITE. A command is accepted on a rising edge where CmdValid && CmdReady. On acceptance, CmdOp/SrcA/SrcB/Dst are latched and the next state is READ_A. Without acceptance, IDLE stays IDLE and WRITE goes to IDLE.
- READ_A: ReadReg=SrcA; ReadData is captured into OpA at the edge.
- READ_B: ReadReg=SrcB; ReadData is captured into OpB at the edge. In all other states ReadReg holds its last value.
- EXEC: Result, CarryOut, and Zero are registered at the edge.
- WRITE: WriteEn=1, Done=1, WriteReg=Dst, WriteData=Result, for exactly one cycle. The register file commits at the edge ending WRITE.
- Latency: accept edge -> WriteEn high 3 cycles later. Back-to-back throughput is one command per 4 cycles.
- Hazards: the next command's READ_A follows the write edge, so read-after-write to the same register returns the new value. No forwarding is needed. SrcA==SrcB==Dst is legal.
- Ops (all modulo 2^DATA_WIDTH):
  - 000 ADD A+B, CarryOut=bit 8 of sum.
  - 001 SUB A-B, CarryOut=1 iff A<B (borrow).
  - 010 AND, 011 OR, 100 XOR: CarryOut=0.
  - 101 MOV: Result=A, CarryOut=0.
  - 110 SHL: Result=A<<1, CarryOut=A[7].
  - 111 SHR logical: Result=A>>1, CarryOut=A[0]. B is read but ignored.
- Zero updates with Result.
- CmdOp/Src/Dst changes after acceptance have no effect. CmdValid without CmdReady is held off with no side effects.

Test Plan:
- Register file reset (reg[i]=i). ADD Src 3, Src 5, Dst 1 -> WriteEn one cycle, 3 cycles after accept; WriteReg=1, WriteData=0x08, CarryOut=0, Zero=0, Done pulse.
- Preload reg2=0xF0, reg4=0x20. ADD Src 2, Src 4, Dst 6 -> 0x10, CarryOut=1. Then SUB Src 4, Src 2, Dst 7 -> 0x30, CarryOut=1 (borrow).
- XOR Src 9, Src 9, Dst 9 -> reg9=0x00, Zero=1. SHR Src 1, Dst 0 -> 0x00, CarryOut=1, Zero=1.
- Back-to-back, CmdValid held high: ADD Src 1, Src 1, Dst 1 issued twice -> reg1=2, then reg1=4 (RAW correct). Accepts occur 4 cycles apart; CmdReady is 0 in READ_A/READ_B/EXEC.
- Assert rst=0 during EXEC of MOV Src 5, Dst 2 -> no WriteEn, all outputs at reset values immediately, reg2 unchanged. After release, a new command completes normally.
- CmdValid pulsed while busy (READ_B) then dropped -> command ignored, no extra write.
